// File: rtl/writeback_stage.sv
// Writeback stage: selects the rd value from packed sources or formatted load data, then issues one-cycle RF write/retire pulses.
// Define WB_INSTRET_EN to add the 64-bit o_instret retired-instruction counter port.
module writeback_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 3,
  parameter int RADDR_W = 5,
  localparam int SEL_W  = $clog2(NUM_SRC + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [SEL_W-1:0]        i_rd_dest_select,
  input  logic [NUM_SRC*XLEN-1:0] i_src_bus,
  input  logic                    i_rd_wen,
  input  logic [RADDR_W-1:0]      i_rd_addr,
  input  logic [2:0]              i_load_funct3,
  input  logic [1:0]              i_load_addr_lo,
  input  logic [XLEN-1:0]         i_dmem_rdata,
  input  logic                    i_dmem_rvalid,
  output logic                    o_rf_wen,
  output logic [RADDR_W-1:0]      o_rf_waddr,
  output logic [XLEN-1:0]         o_rf_wdata,
  output logic                    o_retire,
  output logic                    o_load_fault
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]             o_instret
`endif
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_LOAD = 1'b1;

  logic [0:0]         state_q, state_d;
  logic               rf_wen_q, rf_wen_d;
  logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
  logic               retire_q, retire_d;
  logic               load_fault_q, load_fault_d;
  logic [2:0]         ld_funct3_q, ld_funct3_d;
  logic [1:0]         ld_addr_lo_q, ld_addr_lo_d;
  logic [RADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic               ld_wen_q, ld_wen_d;

  logic [XLEN-1:0]    src_value;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [XLEN-1:0]    ld_value;
  logic               ld_fault;

  // Selects beyond the last real source fall through to zero.
  always_comb begin
    src_value = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (i_rd_dest_select == SEL_W'(k)) begin
        src_value = i_src_bus[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    ld_byte  = i_dmem_rdata[7:0];
    ld_value = '0;
    ld_fault = 1'b0;
    case (ld_addr_lo_q)
      2'd0:    ld_byte = i_dmem_rdata[7:0];
      2'd1:    ld_byte = i_dmem_rdata[15:8];
      2'd2:    ld_byte = i_dmem_rdata[23:16];
      default: ld_byte = i_dmem_rdata[31:24];
    endcase
    ld_half = ld_addr_lo_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (ld_funct3_q)
      3'b000: ld_value = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001: begin
        ld_value = {{(XLEN-16){ld_half[15]}}, ld_half};
        ld_fault = ld_addr_lo_q[0];
      end
      3'b010: begin
        ld_value = i_dmem_rdata;
        ld_fault = (ld_addr_lo_q != 2'd0);
      end
      3'b100: ld_value = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101: begin
        ld_value = {{(XLEN-16){1'b0}}, ld_half};
        ld_fault = ld_addr_lo_q[0];
      end
      default: ld_fault = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    retire_d     = 1'b0;
    load_fault_d = 1'b0;
    ld_funct3_d  = ld_funct3_q;
    ld_addr_lo_d = ld_addr_lo_q;
    ld_rd_d      = ld_rd_q;
    ld_wen_d     = ld_wen_q;
    if (state_q == IDLE) begin
      if (i_valid) begin
        if (i_rd_dest_select == SEL_W'(NUM_SRC)) begin
          ld_funct3_d  = i_load_funct3;
          ld_addr_lo_d = i_load_addr_lo;
          ld_rd_d      = i_rd_addr;
          ld_wen_d     = i_rd_wen;
          state_d      = WAIT_LOAD;
        end else begin
          retire_d = 1'b1;
          if (i_rd_wen && (i_rd_addr != '0)) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = i_rd_addr;
            rf_wdata_d = src_value;
          end
        end
      end
    end else if (i_dmem_rvalid) begin
      state_d = IDLE;
      if (ld_fault) begin
        load_fault_d = 1'b1;
      end else begin
        retire_d = 1'b1;
        if (ld_wen_q && (ld_rd_q != '0)) begin
          rf_wen_d   = 1'b1;
          rf_waddr_d = ld_rd_q;
          rf_wdata_d = ld_value;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      retire_q     <= 1'b0;
      load_fault_q <= 1'b0;
      ld_funct3_q  <= '0;
      ld_addr_lo_q <= '0;
      ld_rd_q      <= '0;
      ld_wen_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      retire_q     <= retire_d;
      load_fault_q <= load_fault_d;
      ld_funct3_q  <= ld_funct3_d;
      ld_addr_lo_q <= ld_addr_lo_d;
      ld_rd_q      <= ld_rd_d;
      ld_wen_q     <= ld_wen_d;
    end
  end

  assign o_ready      = (state_q == IDLE);
  assign o_rf_wen     = rf_wen_q;
  assign o_rf_waddr   = rf_waddr_q;
  assign o_rf_wdata   = rf_wdata_q;
  assign o_retire     = retire_q;
  assign o_load_fault = load_fault_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // Counts alongside the retire pulse so o_instret includes the instruction retiring this cycle.
  always_comb begin
    instret_d = instret_q + {63'd0, retire_d};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign o_instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized bench for writeback_stage against a behavioural model of selection, load formatting and pulses.
module tb_writeback_stage;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 3;
  localparam int RADDR_W = 5;
  localparam int SEL_W   = 2;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n;
  logic                    i_valid;
  logic                    o_ready;
  logic [SEL_W-1:0]        i_rd_dest_select;
  logic [NUM_SRC*XLEN-1:0] i_src_bus;
  logic                    i_rd_wen;
  logic [RADDR_W-1:0]      i_rd_addr;
  logic [2:0]              i_load_funct3;
  logic [1:0]              i_load_addr_lo;
  logic [XLEN-1:0]         i_dmem_rdata;
  logic                    i_dmem_rvalid;
  logic                    o_rf_wen;
  logic [RADDR_W-1:0]      o_rf_waddr;
  logic [XLEN-1:0]         o_rf_wdata;
  logic                    o_retire;
  logic                    o_load_fault;
`ifdef WB_INSTRET_EN
  logic [63:0]             o_instret;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [RADDR_W-1:0] m_waddr;
  logic [XLEN-1:0]    m_wdata;
  longint unsigned    m_instret;

  always #5 i_clk = ~i_clk;

  writeback_stage #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .RADDR_W(RADDR_W)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .i_rd_dest_select (i_rd_dest_select),
    .i_src_bus        (i_src_bus),
    .i_rd_wen         (i_rd_wen),
    .i_rd_addr        (i_rd_addr),
    .i_load_funct3    (i_load_funct3),
    .i_load_addr_lo   (i_load_addr_lo),
    .i_dmem_rdata     (i_dmem_rdata),
    .i_dmem_rvalid    (i_dmem_rvalid),
    .o_rf_wen         (o_rf_wen),
    .o_rf_waddr       (o_rf_waddr),
    .o_rf_wdata       (o_rf_wdata),
    .o_retire         (o_retire),
    .o_load_fault     (o_load_fault)
`ifdef WB_INSTRET_EN
    ,
    .o_instret        (o_instret)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_out(input string tag, input bit wen, input bit retire, input bit fault, input bit ready);
    check({tag, "_wen"},    64'(o_rf_wen),     64'(wen));
    check({tag, "_retire"}, 64'(o_retire),     64'(retire));
    check({tag, "_fault"},  64'(o_load_fault), 64'(fault));
    check({tag, "_ready"},  64'(o_ready),      64'(ready));
    check({tag, "_waddr"},  64'(o_rf_waddr),   64'(m_waddr));
    check({tag, "_wdata"},  64'(o_rf_wdata),   64'(m_wdata));
  endtask

  // Architectural load semantics expressed as shifts, masks and two's-complement offsets.
  function automatic void load_model(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d,
                                     output bit fault, output logic [31:0] v);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * int'(a))) & 32'hFF;
    h = (d >> (16 * (int'(a) / 2))) & 32'hFFFF;
    fault = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
            (((f3 == 3'd1) || (f3 == 3'd5)) && (a % 2 == 1)) ||
            ((f3 == 3'd2) && (a != 2'd0));
    v = '0;
    case (f3)
      3'd0: v = (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1: v = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd2: v = d;
      3'd4: v = b;
      3'd5: v = h;
      default: v = '0;
    endcase
  endfunction

  task automatic idle(input bit stray);
    i_valid       = 1'b0;
    i_dmem_rvalid = stray;
    i_dmem_rdata  = $urandom;
    tick();
    i_dmem_rvalid = 1'b0;
    check_out("idle", 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic issue_op(input int sel, input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [RADDR_W-1:0] rd, input bit wen);
    logic [31:0] srcs [3];
    bit exp_w;
    srcs[0] = s0; srcs[1] = s1; srcs[2] = s2;
    i_valid          = 1'b1;
    i_rd_dest_select = SEL_W'(sel);
    i_src_bus        = {s2, s1, s0};
    i_rd_addr        = rd;
    i_rd_wen         = wen;
    i_load_funct3    = 3'($urandom);
    i_load_addr_lo   = 2'($urandom);
    check("op_ready_in", 64'(o_ready), 64'd1);
    tick();
    exp_w = wen && (rd != 0);
    if (exp_w) begin
      m_waddr = rd;
      m_wdata = (sel < NUM_SRC) ? srcs[sel] : 32'd0;
    end
    m_instret++;
    check_out("op", exp_w, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [1:0] a, input logic [RADDR_W-1:0] rd,
                         input bit wen, input logic [31:0] rdata, input int delay);
    bit fault;
    logic [31:0] v;
    bit exp_w;
    i_valid          = 1'b1;
    i_rd_dest_select = SEL_W'(NUM_SRC);
    i_src_bus        = {$urandom, $urandom, $urandom};
    i_rd_addr        = rd;
    i_rd_wen         = wen;
    i_load_funct3    = f3;
    i_load_addr_lo   = a;
    check("ld_ready_in", 64'(o_ready), 64'd1);
    tick();
    // While waiting, the pipeline presents unrelated requests and rdata noise that must be ignored.
    for (int i = 1; i <= delay; i++) begin
      check_out("ld_wait", 1'b0, 1'b0, 1'b0, 1'b0);
      i_valid          = 1'b1;
      i_rd_dest_select = SEL_W'($urandom_range(0, 3));
      i_rd_addr        = RADDR_W'($urandom);
      i_rd_wen         = 1'b1;
      i_load_funct3    = 3'($urandom);
      i_load_addr_lo   = 2'($urandom);
      i_dmem_rvalid    = (i == delay);
      i_dmem_rdata     = (i == delay) ? rdata : $urandom;
      tick();
    end
    i_valid       = 1'b0;
    i_dmem_rvalid = 1'b0;
    load_model(f3, a, rdata, fault, v);
    exp_w = !fault && wen && (rd != 0);
    if (exp_w) begin
      m_waddr = rd;
      m_wdata = v;
    end
    if (!fault) m_instret++;
    check_out("ld_done", exp_w, !fault, fault, 1'b1);
  endtask

  initial begin
    i_rst_n          = 1'b0;
    i_valid          = 1'b0;
    i_rd_dest_select = '0;
    i_src_bus        = '0;
    i_rd_wen         = 1'b0;
    i_rd_addr        = '0;
    i_load_funct3    = '0;
    i_load_addr_lo   = '0;
    i_dmem_rdata     = '0;
    i_dmem_rvalid    = 1'b0;
    m_waddr          = '0;
    m_wdata          = '0;
    m_instret        = 0;

    tick();
    tick();
    check_out("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    i_rst_n = 1'b1;
    idle(1'b0);

    $display("[TB] ALU writeback");
    issue_op(0, 32'h0000_1234, 32'hAAAA_0001, 32'h0000_0104, 5'd5, 1'b1);
    check("t1_wdata", 64'(o_rf_wdata), 64'h0000_1234);
    check("t1_waddr", 64'(o_rf_waddr), 64'd5);

    $display("[TB] Back-to-back selects");
    issue_op(1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd6, 1'b1);
    issue_op(2, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd7, 1'b1);
    issue_op(0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd8, 1'b1);
    check("t2_last", 64'(o_rf_wdata), 64'h1111_1111);
    idle(1'b1);

    $display("[TB] Byte loads with lane select");
    do_load(3'b000, 2'd3, 5'd9, 1'b1, 32'h80FF_FF7F, 2);
    check("t3_lb", 64'(o_rf_wdata), 64'hFFFF_FF80);
    do_load(3'b100, 2'd3, 5'd9, 1'b1, 32'h80FF_FF7F, 2);
    check("t3_lbu", 64'(o_rf_wdata), 64'h0000_0080);

    $display("[TB] Faults and x0");
    do_load(3'b001, 2'd1, 5'd10, 1'b1, 32'hDEAD_BEEF, 1);
    check("t4_lh_fault", 64'(o_load_fault), 64'd1);
    do_load(3'b010, 2'd0, 5'd0, 1'b1, 32'hCAFE_F00D, 1);
    check("t4_lw_x0_retire", 64'(o_retire), 64'd1);
    check("t4_lw_x0_wen", 64'(o_rf_wen), 64'd0);
    idle(1'b0);

    $display("[TB] Reset during WAIT_LOAD");
    i_valid          = 1'b1;
    i_rd_dest_select = SEL_W'(NUM_SRC);
    i_rd_addr        = 5'd11;
    i_rd_wen         = 1'b1;
    i_load_funct3    = 3'b010;
    i_load_addr_lo   = 2'd0;
    tick();
    check("t5_wait", 64'(o_ready), 64'd0);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    tick();
    i_rst_n   = 1'b1;
    m_waddr   = '0;
    m_wdata   = '0;
    m_instret = 0;
    check_out("t5_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);

    $display("[TB] Retire counting");
    issue_op(0, 32'h5, 32'h6, 32'h7, 5'd1, 1'b1);
    issue_op(1, 32'h5, 32'h6, 32'h7, 5'd0, 1'b1);
    do_load(3'b011, 2'd0, 5'd2, 1'b1, 32'h1234_5678, 1);
    do_load(3'b101, 2'd2, 5'd3, 1'b1, 32'h8765_4321, 3);
    check("t6_wdata", 64'(o_rf_wdata), 64'h0000_8765);
`ifdef WB_INSTRET_EN
    check("t6_instret", o_instret, 64'd3);
`endif

    $display("[TB] Randomized traffic");
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load(3'($urandom), 2'($urandom), RADDR_W'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
                $urandom, $urandom_range(1, 3));
      end else begin
        issue_op($urandom_range(0, NUM_SRC - 1), $urandom, $urandom, $urandom,
                 RADDR_W'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0));
      end
      if ($urandom_range(0, 3) == 0) idle(1'($urandom));
    end
    idle(1'b0);
`ifdef WB_INSTRET_EN
    check("final_instret", o_instret, 64'(m_instret));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
